alu_exec_unit: RTL

//  Execute-stage ALU that consumes the 3-bit ALU select produced by ALU control
//  and computes the result on two operands. Inputs arrive over a valid/ready

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_exec_unit_core.sv | 42 ++++
 rtl/alu_exec_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU select codes, result flag struct and pipeline state shared by the ALU blocks
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Status that travels alongside the result through the output stage
    typedef struct packed {
        logic zero;
        logic illeg;
        logic ovf;
    } alu_flags_t;

    localparam alu_flags_t FLAGS_RESET = '{zero: 1'b1, illeg: 1'b0, ovf: 1'b0};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/alu_exec_unit_core.sv
// alu_core: combinational ALU compute; overflow flag only when ALU_OVF_EN is defined
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Select the operation result and derive the status flags from it
    always_comb begin
        result      = '0;
        flags.illeg = 1'b0;
        case (sel)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = sum;
            ALU_SUB: result = diff;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: flags.illeg = 1'b1;
        endcase
        flags.zero = (result == '0);
`ifdef ALU_OVF_EN
        flags.ovf = (sel == ALU_ADD) ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
                    (sel == ALU_SUB) ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) :
                    1'b0;
`else
        flags.ovf = 1'b0;
`endif
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered output and 1-entry skid buffer (ALU_OVF_EN enables out_ovf)
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illeg,
    output logic             out_ovf
);

    pipe_state_t      state;
    pipe_state_t      state_nxt;
    logic [WIDTH-1:0] core_res;
    alu_flags_t       core_flags;
    logic [WIDTH-1:0] out_res;
    alu_flags_t       out_flags;
    logic [WIDTH-1:0] skid_res;
    alu_flags_t       skid_flags;
    logic             accept;
    logic             load_out;
    logic             load_skid;
    logic             take_skid;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .sel    (in_sel),
        .a      (in_a),
        .b      (in_b),
        .result (core_res),
        .flags  (core_flags)
    );

    assign accept    = in_valid && in_ready;
    assign load_out  = accept && (state == ST_EMPTY || (state == ST_ONE && out_ready));
    assign load_skid = accept && state == ST_ONE && !out_ready;
    assign take_skid = state == ST_FULL && out_ready;

    // Pipeline occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Occupancy transitions; flush overrides every other event
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: state_nxt = accept ? ST_ONE : ST_EMPTY;
            ST_ONE:   state_nxt = (accept && !out_ready) ? ST_FULL :
                                  (!accept && out_ready) ? ST_EMPTY : ST_ONE;
            ST_FULL:  state_nxt = out_ready ? ST_ONE : ST_FULL;
            default:  state_nxt = ST_EMPTY;
        endcase
        if (flush) state_nxt = ST_EMPTY;
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        in_ready  = (state != ST_FULL);
        out_valid = (state != ST_EMPTY);
    end

    // Output stage and skid buffer data; a flush leaves contents as don't-care
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_res    <= '0;
            out_flags  <= FLAGS_RESET;
            skid_res   <= '0;
            skid_flags <= FLAGS_RESET;
        end else if (!flush) begin
            if (load_out) begin
                out_res   <= core_res;
                out_flags <= core_flags;
            end else if (take_skid) begin
                out_res   <= skid_res;
                out_flags <= skid_flags;
            end
            if (load_skid) begin
                skid_res   <= core_res;
                skid_flags <= core_flags;
            end
        end
    end

    assign out_result = out_res;
    assign out_zero   = out_flags.zero;
    assign out_illeg  = out_flags.illeg;
    assign out_ovf    = out_flags.ovf;

endmodule
